// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and byte helpers for the iterative AES-128
// encryption controller.
//   aes_state_t : 4x4 byte matrix indexed [row][col]
//   aes_fsm_e   : controller states IDLE / ROUND / FINAL / DONE
//   xtime()     : multiply by x in GF(2^8)
//   sbox()      : forward S-box lookup
//   to_state() / to_block() : FIPS-197 column-major byte mapping
//                 (byte 0 = bits [127:120], byte n sits at row n%4, col n/4)
package aes_pkg;

  localparam int         NR        = 10;
  localparam int         KEY_W     = 128;
  localparam int         BLK_W     = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef logic [0:3][0:3][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } aes_fsm_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic aes_state_t to_state(input logic [BLK_W-1:0] blk);
    aes_state_t st;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = blk[BLK_W-1-8*(4*c+r) -: 8];
    return st;
  endfunction

  function automatic logic [BLK_W-1:0] to_block(input aes_state_t st);
    logic [BLK_W-1:0] blk;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        blk[BLK_W-1-8*(4*c+r) -: 8] = st[r][c];
    return blk;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-expansion step, purely combinational.
//   rk      : current round key (words w0..w3, w0 in the top 32 bits)
//   rcon    : round constant for this step
//   next_rk : following round key
module aes_key_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] rk,
  input  logic [7:0]       rcon,
  output logic [KEY_W-1:0] next_rk
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, temp_w;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk;

  // RotWord then SubWord on the last word, then fold in rcon on the top byte.
  assign rot_w  = {w3[23:0], w3[31:24]};
  assign sub_w  = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                   sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
  assign temp_w = sub_w ^ {rcon, 24'h000000};

  // Each new word chains off the one before it.
  assign n0 = w0 ^ temp_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_rk = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_iter_ctrl.sv
// aes_iter_ctrl: iterative AES-128 encryption controller. One round datapath
// is reused for rounds 1..10; the round key is expanded one step per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : plaintext/key handshake (sampled on accept only)
//   in_plain, in_key    : 128-bit plaintext and key, FIPS-197 byte order
//   out_valid/out_ready : ciphertext handshake, held until consumed
//   out_cipher          : registered ciphertext
//   busy                : high while rounds are in progress
//   round_idx           : current round number (debug/trace)
// Build option: define AES_ABORT_EN to add the abort input, which drops the
// in-flight block and returns to IDLE from ROUND or FINAL.
module aes_iter_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_plain,
  input  logic [KEY_W-1:0] in_key,
`ifdef AES_ABORT_EN
  input  logic             abort,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_cipher,
  output logic             busy,
  output logic [3:0]       round_idx
);

  aes_fsm_e         fsm_q, fsm_d;
  logic [BLK_W-1:0] st_q;
  logic [KEY_W-1:0] rk_q, next_rk;
  logic [7:0]       rcon_q;
  logic             abort_hit;
  logic [BLK_W-1:0] round_out;
  aes_state_t       sb, sr, mc;

`ifdef AES_ABORT_EN
  assign abort_hit = abort && (fsm_q == ROUND || fsm_q == FINAL);
`else
  assign abort_hit = 1'b0;
`endif

  function automatic logic [31:0] mix_col(input logic [7:0] a0, a1, a2, a3);
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  aes_key_step u_key_step (
    .rk      (rk_q),
    .rcon    (rcon_q),
    .next_rk (next_rk)
  );

  // Round datapath: SubBytes -> ShiftRows -> MixColumns (skipped in FINAL).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    sb = to_state(st_q);
    sr = '0;
    mc = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sb[r][c] = sbox(sb[r][c]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[r][c] = sb[r][(c + r) % 4];
    for (int c = 0; c < 4; c++)
      {mc[0][c], mc[1][c], mc[2][c], mc[3][c]} =
        mix_col(sr[0][c], sr[1][c], sr[2][c], sr[3][c]);
    round_out = to_block((fsm_q == FINAL) ? sr : mc) ^ next_rk;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state logic.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:  if (in_valid) fsm_d = ROUND;
      ROUND: if (abort_hit) fsm_d = IDLE;
             else if (round_idx == 4'(NR - 1)) fsm_d = FINAL;
      FINAL: fsm_d = abort_hit ? IDLE : DONE;
      DONE:  if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    in_ready = (fsm_q == IDLE);
    busy     = (fsm_q == ROUND) || (fsm_q == FINAL);
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the block state and key are cleared too, not just the control
      // flops, so nothing of a discarded block lingers after reset.
      st_q       <= '0;
      rk_q       <= '0;
      rcon_q     <= '0;
      round_idx  <= '0;
      out_valid  <= 1'b0;
      out_cipher <= '0;
    end else begin
      unique case (fsm_q)
        IDLE: if (in_valid) begin
          st_q      <= in_plain ^ in_key;
          rk_q      <= in_key;
          rcon_q    <= RCON_INIT;
          round_idx <= 4'd1;
        end
        ROUND, FINAL: begin
          if (abort_hit) begin
            st_q      <= '0;
            rk_q      <= '0;
            rcon_q    <= '0;
            round_idx <= '0;
          end else begin
            st_q   <= round_out;
            rk_q   <= next_rk;
            rcon_q <= xtime(rcon_q);
            if (fsm_q == ROUND) begin
              round_idx <= round_idx + 4'd1;
            end else begin
              out_cipher <= round_out;
              out_valid  <= 1'b1;
            end
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          round_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// tb_aes_iter_ctrl: self-checking bench for aes_iter_ctrl. Expected
// ciphertexts come from FIPS-197 vectors and from a byte-level AES-128 model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
// Define AES_ABORT_EN to also exercise the abort input.
module tb_aes_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_plain;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_cipher;
  logic         busy;
  logic [3:0]   round_idx;
`ifdef AES_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_tab [256];

  aes_iter_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_plain   (in_plain),
    .in_key     (in_key),
`ifdef AES_ABORT_EN
    .abort      (abort),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cipher (out_cipher),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] p, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sb_tab[s[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r+4*c] = s[r + 4*((c + r) % 4)];
        for (int i = 0; i < 16; i++) s[i] = t[i];
        if (rnd < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
          end
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Present a block at a falling edge and return at the falling edge after
  // the accept edge, with the inputs scrambled.
  task automatic start_block(input logic [127:0] p, input logic [127:0] k);
    int n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_plain = p;
    in_key   = k;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_plain = {$urandom, $urandom, $urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom, $urandom};
    check("busy_after_accept", busy, 1);
    check("round_after_accept", round_idx, 1);
    check("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic run_block(input logic [127:0] p, input logic [127:0] k, input int stall,
                           input bit inject, input logic [127:0] p2, input logic [127:0] k2,
                           input logic [127:0] exp);
    out_ready = (stall == 0);
    start_block(p, k);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c < 10) begin
        check("no_early_out_valid", out_valid, 0);
        check("round_idx_progress", round_idx, c + 1);
        check("busy_in_rounds", busy, 1);
      end
      if (inject && c == 3) begin
        in_valid = 1'b1;
        in_plain = p2;
        in_key   = k2;
      end
    end
    check("out_valid_at_latency", out_valid, 1);
    check("cipher", out_cipher, exp);
    check("busy_done", busy, 0);
    check("in_ready_done", in_ready, 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_cipher", out_cipher, exp);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_round_idx", round_idx, 0);
  endtask

  // ---------------- main sequence ----------------
  localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_P  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [127:0] rp, rk;
    int           st;
    build_sbox();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_plain  = '0;
    in_key    = '0;
    out_ready = 1'b1;
`ifdef AES_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_cipher", out_cipher, 0);
    check("reset_busy", busy, 0);
    check("reset_round_idx", round_idx, 0);
    rst = 1'b0;

    // FIPS-197 C.1, consumer always ready.
    run_block(C1_P, C1_K, 0, 1'b0, '0, '0, C1_C);

    // FIPS-197 Appendix B with 20 cycles of backpressure.
    run_block(B_P, B_K, 20, 1'b0, '0, '0, B_C);

    // A second block offered at round 4 must wait for IDLE.
    rp = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    run_block(C1_P, C1_K, 0, 1'b1, rp, rk, C1_C);
    run_block(rp, rk, 0, 1'b0, '0, '0, ref_encrypt(rp, rk));

    // Reset at round 6 discards the block.
    start_block(C1_P, C1_K);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("round_before_reset", round_idx, 6);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_round_idx", round_idx, 0);
    check("midrst_busy", busy, 0);
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_out_valid", out_valid, 0);
    end
    run_block(C1_P, C1_K, 0, 1'b0, '0, '0, C1_C);

`ifdef AES_ABORT_EN
    // Abort at round 3 returns to IDLE without producing output.
    start_block(C1_P, C1_K);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("round_before_abort", round_idx, 3);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_round_idx", round_idx, 0);
    check("abort_out_valid", out_valid, 0);
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_no_out_valid", out_valid, 0);
    end
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_ignored", in_ready, 1);
    run_block(B_P, B_K, 0, 1'b0, '0, '0, B_C);
`endif

    // Random blocks with random backpressure.
    for (int i = 0; i < 4; i++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      st = int'($urandom_range(0, 3));
      run_block(rp, rk, st, 1'b0, '0, '0, ref_encrypt(rp, rk));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
